// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-to-datapath/memory bundle for the multicycle core controller
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             mem_req;
  logic             iord;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             branch;
  logic [1:0]       pc_src;
  logic [1:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             illegal_op;
  logic             bus_error;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;

  modport master (
    input  op, mem_ready,
    output mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_op,
           alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write, illegal_op,
           bus_error, instret, state
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_op,
           alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write, illegal_op,
           bus_error, instret, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM with memory timeout and retire counter
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  instret_q;

  logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, branch_c, reg_write_c;
  logic       illegal_c, bus_err_c, retire_c;
  logic       timeout_hit;

  // Only meaningful in the three memory states; ready on the same cycle always wins.
  assign timeout_hit = (TIMEOUT != 0) && !bus.mem_ready &&
                       (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || bus_err_c)
        wait_q <= '0;
      else if (!bus.mem_ready && (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR))
        wait_q <= wait_q + 1'b1;
      if (retire_c)
        instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    branch_c      = 1'b0;
    reg_write_c   = 1'b0;
    illegal_c     = 1'b0;
    bus_err_c     = 1'b0;
    retire_c      = 1'b0;
    bus.iord      = 1'b0;
    bus.pc_src    = 2'b00;
    bus.alu_op    = 2'b00;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.reg_dst   = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c     = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_hit) begin
          bus_err_c = 1'b1;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.op)
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h00:        state_d = S_RTYPE_EX;
          6'h04:        state_d = S_BEQ;
          6'h08:        state_d = S_ADDI_EX;
          6'h02:        state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d = (bus.op == 6'h23) ? S_MEMRD : (bus.op == 6'h2B) ? S_MEMWR : S_FETCH;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        bus.iord  = 1'b1;
        if (bus.mem_ready)
          state_d = S_MEMWB;
        else if (timeout_hit) begin
          bus_err_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        reg_write_c    = 1'b1;
        retire_c       = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (timeout_hit) begin
          bus_err_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_RTYPE_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        bus.reg_dst = 1'b1;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 2'b01;
        branch_c      = 1'b1;
        retire_c      = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        bus.pc_src = 2'b10;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset state is FETCH, whose Moore outputs include mem_req; hold strobes low while in reset.
  assign bus.mem_req    = mem_req_c   & rst_n;
  assign bus.mem_write  = mem_write_c & rst_n;
  assign bus.ir_write   = ir_write_c  & rst_n;
  assign bus.pc_write   = pc_write_c  & rst_n;
  assign bus.branch     = branch_c    & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;
  assign bus.illegal_op = illegal_c   & rst_n;
  assign bus.bus_error  = bus_err_c   & rst_n;
  assign bus.instret    = instret_q;
  assign bus.state      = state_q;
endmodule
